// File: rtl/result_collector.sv
// Result collector: packs NUM captured result items per batch into two ping-pong banks
// and presents each full batch through a valid/ack handshake, dropping items when both banks are full.
module result_collector #(
   parameter int NUM        = 1000,
   parameter int ITEM_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [ITEM_WIDTH-1:0]         res_i,
   input  logic                          res_valid_i,
   output logic                          batch_valid_o,
   output logic [NUM*ITEM_WIDTH-1:0]     batch_data_o,
   input  logic                          batch_ack_i,
   output logic [$clog2(NUM+1)-1:0]      fill_cnt_o,
   output logic                          overflow_o,
   output logic [CNT_WIDTH-1:0]          drop_cnt_o,
   output logic                          dbg_stall_o
);

   localparam int FW = $clog2(NUM+1);
   localparam int DW = NUM*ITEM_WIDTH;

   // Handshake: a batch transfers on every rising edge where batch_valid_o and batch_ack_i are both 1;
   // batch_data_o holds steady while batch_valid_o=1 until that edge, and acks without valid are ignored.

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t               r_state;
   logic [DW-1:0]        r_bank0;
   logic [DW-1:0]        r_bank1;
   logic [1:0]           r_full;
   logic                 r_fill_sel;
   logic                 r_rd_sel;
   logic [FW-1:0]        r_fill_cnt;
   logic                 r_overflow;
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   logic                 w_ack;
   logic                 w_capture;
   logic                 w_last;
   logic [1:0]           w_full_set;
   logic [1:0]           w_full_clr;

   assign w_ack     = batch_ack_i & r_full[r_rd_sel];
   assign w_capture = (r_state == ST_FILL) & res_valid_i;
   assign w_last    = w_capture & (r_fill_cnt == FW'(NUM-1));

   always_comb begin
      w_full_set = 2'b00;
      w_full_clr = 2'b00;
      if (w_last) w_full_set[r_fill_sel] = 1'b1;
      if (w_ack)  w_full_clr[r_rd_sel]   = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= ST_FILL;
         r_bank0    <= '0;
         r_bank1    <= '0;
         r_full     <= 2'b00;
         r_fill_sel <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_fill_cnt <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_full <= (r_full | w_full_set) & ~w_full_clr;
         if (w_ack) r_rd_sel <= ~r_rd_sel;

         case (r_state)
            ST_FILL: begin
               if (w_capture) begin
                  if (r_fill_sel) r_bank1[int'(r_fill_cnt)*ITEM_WIDTH +: ITEM_WIDTH] <= res_i;
                  else            r_bank0[int'(r_fill_cnt)*ITEM_WIDTH +: ITEM_WIDTH] <= res_i;
                  r_fill_cnt <= w_last ? '0 : r_fill_cnt + 1'b1;
               end
               // The fill bank is never full here, so any ack this edge frees the other bank.
               if (w_last) begin
                  if (!r_full[~r_fill_sel] || w_ack) r_fill_sel <= ~r_fill_sel;
                  else                               r_state    <= ST_STALL;
               end
            end
            ST_STALL: begin
               if (res_valid_i) begin
                  r_overflow <= 1'b1;
                  if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
               end
               if (w_ack) begin
                  r_state    <= ST_FILL;
                  r_fill_sel <= r_rd_sel;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign batch_valid_o = r_full[r_rd_sel];
   assign batch_data_o  = r_rd_sel ? r_bank1 : r_bank0;
   assign fill_cnt_o    = r_fill_cnt;
   assign overflow_o    = r_overflow;
   assign drop_cnt_o    = r_drop_cnt;
   assign dbg_stall_o   = (r_state == ST_STALL);

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios on a NUM=4 instance, randomized traffic against a
// batch-queue reference model, and drop-counter saturation on a NUM=2, CNT_WIDTH=2 instance.
module tb_result_collector;

   localparam int NUM = 4;
   localparam int IW  = 8;
   localparam int DW  = NUM*IW;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i = 1'b1;
   logic [IW-1:0] res_i = '0;
   logic          res_valid_i = 1'b0;
   logic          batch_ack_i = 1'b0;
   logic          batch_valid_o;
   logic [DW-1:0] batch_data_o;
   logic [2:0]    fill_cnt_o;
   logic          overflow_o;
   logic [15:0]   drop_cnt_o;
   logic          dbg_stall_o;

   logic          rst2 = 1'b1;
   logic [IW-1:0] res2 = '0;
   logic          v2 = 1'b0;
   logic          ack2 = 1'b0;
   logic          bv2;
   logic [15:0]   bd2;
   logic [1:0]    fc2;
   logic          ov2;
   logic [1:0]    dc2;
   logic          dbg2;

   result_collector #(.NUM(NUM), .ITEM_WIDTH(IW), .CNT_WIDTH(16)) dut (
      .clk_i(clk), .reset_i(reset_i), .res_i(res_i), .res_valid_i(res_valid_i),
      .batch_valid_o(batch_valid_o), .batch_data_o(batch_data_o), .batch_ack_i(batch_ack_i),
      .fill_cnt_o(fill_cnt_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
      .dbg_stall_o(dbg_stall_o)
   );

   result_collector #(.NUM(2), .ITEM_WIDTH(IW), .CNT_WIDTH(2)) dut2 (
      .clk_i(clk), .reset_i(rst2), .res_i(res2), .res_valid_i(v2),
      .batch_valid_o(bv2), .batch_data_o(bd2), .batch_ack_i(ack2),
      .fill_cnt_o(fc2), .overflow_o(ov2), .drop_cnt_o(dc2), .dbg_stall_o(dbg2)
   );

   int n_total = 0;
   int n_bad   = 0;

   // reference model: queue of completed batches awaiting readout, plus the partial batch
   logic [DW-1:0] exp_q[$];
   logic [IW-1:0] m_part[$];
   int            m_drop = 0;
   bit            m_ovf  = 1'b0;

   task automatic model_clear();
      exp_q.delete();
      m_part.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [IW-1:0] d, input logic a);
      bit            ack_taken;
      logic [DW-1:0] b;
      ack_taken = a && (exp_q.size() > 0);
      if (v) begin
         if (exp_q.size() == 2) begin
            m_ovf  = 1'b1;
            m_drop = m_drop + 1;
         end else begin
            m_part.push_back(d);
            if (m_part.size() == NUM) begin
               b = '0;
               for (int k = 0; k < NUM; k++) b[k*IW +: IW] = m_part[k];
               exp_q.push_back(b);
               m_part.delete();
            end
         end
      end
      if (ack_taken) void'(exp_q.pop_front());
   endtask

   // driver tasks
   task automatic tick(input logic v, input logic [IW-1:0] d, input logic a);
      res_valid_i = v;
      res_i       = d;
      batch_ack_i = a;
      @(posedge clk);
      model_edge(v, d, a);
      #1;
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      res_valid_i = 1'b1;
      res_i       = 8'h5A;
      batch_ack_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i     = 1'b0;
      res_valid_i = 1'b0;
      batch_ack_i = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", batch_valid_o); end
      n_total++; if (batch_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", batch_data_o); end
      n_total++; if (fill_cnt_o !== 3'd0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", fill_cnt_o); end
      n_total++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
      n_total++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
   endtask

   task automatic test_single_batch();
      logic [IW-1:0] items[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, items[i], 1'b0);
         n_total++; if (fill_cnt_o !== 3'((i + 1) % 4)) begin n_bad++; $display("FAIL single_fill[%0d]: got %0d want %0d", i, fill_cnt_o, (i + 1) % 4); end
         n_total++; if (batch_valid_o !== (i == 3)) begin n_bad++; $display("FAIL single_valid[%0d]: got %b want %b", i, batch_valid_o, i == 3); end
      end
      n_total++; if (batch_data_o !== 32'h44332211) begin n_bad++; $display("FAIL single_data: got %h want 44332211", batch_data_o); end
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_ack: got %b want 0", batch_valid_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, IW'(i), 1'b0);
         if (i >= 4) begin
            n_total++; if (batch_data_o !== 32'h04030201) begin n_bad++; $display("FAIL b2b_first[%0d]: got %h want 04030201", i, batch_data_o); end
         end
      end
      n_total++; if (fill_cnt_o !== 3'd0) begin n_bad++; $display("FAIL b2b_fill: got %0d want 0", fill_cnt_o); end
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_hold: got %b want 1", batch_valid_o); end
      n_total++; if (batch_data_o !== 32'h08070605) begin n_bad++; $display("FAIL b2b_second: got %h want 08070605", batch_data_o); end
      tick(1'b0, 8'h00, 1'b0);
      n_total++; if (batch_data_o !== 32'h08070605) begin n_bad++; $display("FAIL b2b_stable: got %h want 08070605", batch_data_o); end
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", batch_valid_o); end
      n_total++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got %b want 0", overflow_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 11; i++) tick(1'b1, IW'(i), 1'b0);
      n_total++; if (drop_cnt_o !== 16'd3) begin n_bad++; $display("FAIL ovf_drop3: got %0d want 3", drop_cnt_o); end
      n_total++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
      tick(1'b1, 8'd12, 1'b1);
      n_total++; if (drop_cnt_o !== 16'd4) begin n_bad++; $display("FAIL ovf_drop_on_ack: got %0d want 4", drop_cnt_o); end
      n_total++; if (batch_data_o !== 32'h08070605) begin n_bad++; $display("FAIL ovf_second: got %h want 08070605", batch_data_o); end
      tick(1'b1, 8'd13, 1'b0);
      n_total++; if (fill_cnt_o !== 3'd1) begin n_bad++; $display("FAIL ovf_resume: got %0d want 1", fill_cnt_o); end
      for (int i = 14; i <= 16; i++) tick(1'b1, IW'(i), 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_data_o !== 32'h100F0E0D) begin n_bad++; $display("FAIL ovf_third: got %h want 100f0e0d", batch_data_o); end
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got %b want 0", batch_valid_o); end
      n_total++; if (drop_cnt_o !== 16'd4) begin n_bad++; $display("FAIL ovf_drop_final: got %0d want 4", drop_cnt_o); end
   endtask

   // entered with overflow set and a nonzero drop count left over from test_overflow
   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) tick(1'b1, IW'(8'h21 + i), 1'b0);
      n_total++; if (batch_data_o !== 32'h24232221) begin n_bad++; $display("FAIL mid_batch0: got %h want 24232221", batch_data_o); end
      do_reset();
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", batch_valid_o); end
      n_total++; if (fill_cnt_o !== 3'd0) begin n_bad++; $display("FAIL mid_fill: got %0d want 0", fill_cnt_o); end
      n_total++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL mid_drop: got %0d want 0", drop_cnt_o); end
      n_total++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow_o); end
      for (int i = 0; i < 4; i++) tick(1'b1, IW'(8'hA1 + i), 1'b0);
      n_total++; if (batch_data_o !== 32'hA4A3A2A1) begin n_bad++; $display("FAIL mid_fresh: got %h want a4a3a2a1", batch_data_o); end
      tick(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_spurious_ack();
      tick(1'b0, 8'h00, 1'b1);
      n_total++; if (batch_valid_o !== 1'b0) begin n_bad++; $display("FAIL spur_valid: got %b want 0", batch_valid_o); end
      tick(1'b1, 8'h31, 1'b1);
      tick(1'b1, 8'h32, 1'b1);
      tick(1'b1, 8'h33, 1'b0);
      tick(1'b1, 8'h34, 1'b1);
      n_total++; if (batch_valid_o !== 1'b1) begin n_bad++; $display("FAIL spur_present: got %b want 1", batch_valid_o); end
      n_total++; if (batch_data_o !== 32'h34333231) begin n_bad++; $display("FAIL spur_data: got %h want 34333231", batch_data_o); end
      tick(1'b0, 8'h00, 1'b0);
      n_total++; if (batch_valid_o !== 1'b1) begin n_bad++; $display("FAIL spur_hold: got %b want 1", batch_valid_o); end
      tick(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 500; c++) begin
         tick($urandom_range(3, 0) != 0, IW'($urandom_range(255, 0)), (c % 100 < 50) ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 0));
         n_total++; if (batch_valid_o !== (exp_q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, batch_valid_o, exp_q.size() > 0); end
         if (exp_q.size() > 0) begin
            n_total++; if (batch_data_o !== exp_q[0]) begin n_bad++; $display("FAIL rnd_data@%0d: got %h want %h", c, batch_data_o, exp_q[0]); end
         end
         n_total++; if (fill_cnt_o !== 3'(m_part.size())) begin n_bad++; $display("FAIL rnd_fill@%0d: got %0d want %0d", c, fill_cnt_o, m_part.size()); end
         n_total++; if (overflow_o !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, overflow_o, m_ovf); end
         n_total++; if (drop_cnt_o !== 16'(m_drop)) begin n_bad++; $display("FAIL rnd_drop@%0d: got %0d want %0d", c, drop_cnt_o, m_drop); end
      end
   endtask

   task automatic test_saturate();
      int drops;
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      n_total++; if (dc2 !== 2'd0) begin n_bad++; $display("FAIL sat_reset: got %0d want 0", dc2); end
      v2 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         res2 = IW'(k);
         @(posedge clk); #1;
         drops = (k > 4) ? k - 4 : 0;
         n_total++; if (dc2 !== 2'((drops > 3) ? 3 : drops)) begin n_bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, dc2, (drops > 3) ? 3 : drops); end
         n_total++; if (ov2 !== (drops > 0)) begin n_bad++; $display("FAIL sat_ovf[%0d]: got %b want %b", k, ov2, drops > 0); end
      end
      v2 = 1'b0;
      ack2 = 1'b1;
      @(posedge clk); #1;
      ack2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (ov2 !== 1'b1) begin n_bad++; $display("FAIL sat_sticky: got %b want 1", ov2); end
      n_total++; if (dc2 !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %0d want 3", dc2); end
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      n_total++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL sat_clear: got %b want 0", ov2); end
   endtask

   initial begin
      test_reset();
      test_single_batch();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_spurious_ack();
      test_random();
      test_saturate();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
